// File: rtl/bcd_serial_alu.sv
// Purpose    : digit-serial 6502-family ALU (ADD/SUB with binary or BCD adjust, logic, inc/dec, shifts).
// Latency    : ADD/SUB DIGITS+1 cycles from start to done; all other ops 2 cycles; back-to-back every DIGITS+1.
// Backpressure: start is taken only while busy=0 (IDLE or the done cycle); start while busy is dropped.
//
// Ports: clk/nRESET (async, active-low); start/op/d_flag/carry_in/a/b request, captured on acceptance;
//        busy, done (1-cycle pulse), result and c/v/n/z_out are registered and hold between done pulses.
// Build option: define BCD_SERIAL_ALU_NMOS_FLAGS_EN for NMOS-style decimal N/Z flags; undefined gives
//        N/Z taken from the final BCD result.
module bcd_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             d_flag,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v_out,
    output logic             n_out,
    output logic             z_out
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4, OP_INC = 4'd5, OP_DEC = 4'd6, OP_PASS = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8, OP_ASL = 4'd9, OP_ROR = 4'd10, OP_ROL = 4'd11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             dec_q, dec_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bin_c_q, bin_c_d;
    logic             dec_c_q, dec_c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
    logic             busy_q, busy_d, done_q, done_d;

    // ---------------- digit datapath (operands shift right one digit per RUN cycle) ----------------
    logic             is_arith, is_sub, dec_add, dec_sub, last_dig;
    logic [3:0]       b_dig, dig;
    logic [4:0]       t_bin, t_dec, t_adj;
    logic [WIDTH-1:0] acc_nx;
    logic             ar_c, ar_x, ar_v, ar_n, ar_z;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_sub   = (op_q == OP_SUB);
    assign dec_add  = dec_q && !is_sub;
    assign dec_sub  = dec_q && is_sub;
    assign last_dig = (cnt_q == CW'(DIGITS - 1));
    assign b_dig    = is_sub ? ~b_q[3:0] : b_q[3:0];

    // Binary chain always runs; the decimal-add chain carries its own adjusted carry.
    assign t_bin = {1'b0, a_q[3:0]} + {1'b0, b_dig} + {4'b0000, bin_c_q};
    assign t_dec = {1'b0, a_q[3:0]} + {1'b0, b_dig} + {4'b0000, dec_c_q};
    // Max 9+9+1 -> 25 after adjust, so bit 4 is exactly "adjusted digit > 15".
    assign t_adj = (t_dec > 5'd9) ? (t_dec + 5'd6) : t_dec;

    always_comb begin
        dig = t_bin[3:0];
        if (dec_add) begin
            dig = t_adj[3:0];
        end else if (dec_sub && !t_bin[4]) begin
            dig = t_bin[3:0] - 4'd6;
        end
    end

    assign acc_nx = (acc_q >> 4) | (WIDTH'(dig) << (WIDTH - 4));

    // Sign bits of the operands are bit 3 of the top digit, which sits in the low nibble on the last step.
    assign ar_c = dec_add ? t_adj[4] : t_bin[4];
    assign ar_x = dec_add ? t_dec[3] : acc_nx[WIDTH-1];
    assign ar_v = ~(a_q[3] ^ b_dig[3]) & (ar_x ^ a_q[3]);

`ifdef BCD_SERIAL_ALU_NMOS_FLAGS_EN
    // Pure binary result assembled in parallel; NMOS decimal N/Z come from it.
    logic [WIDTH-1:0] bin_q, bin_d, bin_nx;
    assign bin_nx = (bin_q >> 4) | (WIDTH'(t_bin[3:0]) << (WIDTH - 4));
    assign ar_n   = dec_add ? t_dec[3] : bin_nx[WIDTH-1];
    assign ar_z   = (bin_nx == '0);
    always_comb begin
        bin_d = bin_q;
        if (state_q == ST_RUN && is_arith) begin
            bin_d = bin_nx;
        end
    end
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            bin_q <= '0;
        end else begin
            bin_q <= bin_d;
        end
    end
`else
    assign ar_n = acc_nx[WIDTH-1];
    assign ar_z = (acc_nx == '0);
`endif

    // ---------------- single-cycle ops ----------------
    logic [WIDTH-1:0] lg_res;
    logic             lg_c;

    always_comb begin
        lg_res = '0;
        lg_c   = 1'b0;
        case (op_q)
            OP_AND:  lg_res = a_q & b_q;
            OP_ORA:  lg_res = a_q | b_q;
            OP_EOR:  lg_res = a_q ^ b_q;
            OP_INC:  {lg_c, lg_res} = {1'b0, b_q} + (WIDTH+1)'(1);
            OP_DEC:  {lg_c, lg_res} = {1'b0, b_q} + {1'b0, {WIDTH{1'b1}}};
            OP_PASS: lg_res = b_q;
            OP_LSR:  begin lg_res = {1'b0, b_q[WIDTH-1:1]};   lg_c = b_q[0];       end
            OP_ASL:  begin lg_res = {b_q[WIDTH-2:0], 1'b0};   lg_c = b_q[WIDTH-1]; end
            OP_ROR:  begin lg_res = {cin_q, b_q[WIDTH-1:1]};  lg_c = b_q[0];       end
            OP_ROL:  begin lg_res = {b_q[WIDTH-2:0], cin_q};  lg_c = b_q[WIDTH-1]; end
            default: begin lg_res = '0; lg_c = 1'b0; end
        endcase
    end

    // ---------------- control ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dec_d    = dec_q;
        cin_d    = cin_q;
        a_d      = a_q;
        b_d      = b_q;
        bin_c_d  = bin_c_q;
        dec_c_d  = dec_c_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        n_d      = n_q;
        z_d      = z_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (start) begin
                    op_d    = op;
                    dec_d   = d_flag;
                    cin_d   = carry_in;
                    a_d     = a;
                    b_d     = b;
                    bin_c_d = carry_in;
                    dec_c_d = carry_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (is_arith) begin
                    a_d     = a_q >> 4;
                    b_d     = b_q >> 4;
                    bin_c_d = t_bin[4];
                    dec_c_d = t_adj[4];
                    acc_d   = acc_nx;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_dig) begin
                        result_d = acc_nx;
                        c_d      = ar_c;
                        v_d      = ar_v;
                        n_d      = ar_n;
                        z_d      = ar_z;
                        state_d  = ST_FIN;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end else begin
                    result_d = lg_res;
                    c_d      = lg_c;
                    v_d      = 1'b0;
                    n_d      = lg_res[WIDTH-1];
                    z_d      = (lg_res == '0);
                    state_d  = ST_FIN;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            dec_q    <= 1'b0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            bin_c_q  <= 1'b0;
            dec_c_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dec_q    <= dec_d;
            cin_q    <= cin_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bin_c_q  <= bin_c_d;
            dec_c_q  <= dec_c_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            c_q      <= c_d;
            v_q      <= v_d;
            n_q      <= n_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_q;
    assign v_out  = v_q;
    assign n_out  = n_q;
    assign z_out  = z_q;

endmodule

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Parametrised, digit-serial 6502-family ALU for the CPU datapath and the coprocessor/tube arithmetic path. It accepts one operation per start/done handshake, registers its operands, and processes ADD/SUB one 4-bit digit per cycle, least-significant digit first, with binary or decimal (BCD) adjust. It is a generalised successor of the single-byte combinational ALU: any width in multiples of 4 bits, registered outputs, and selectable NMOS or corrected decimal-mode flags.

## Interface
- WIDTH, 8, operand/result width; multiple of 4, ≥4; DIGITS = WIDTH/4
- clk  in  1  system clock, rising edge
- nRESET  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only when busy=0
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORA, 4 EOR, 5 INC, 6 DEC, 7 PASS, 8 LSR, 9 ASL, 10 ROR, 11 ROL, 12–15 illegal
- d_flag  in  1  decimal mode; affects ADD/SUB only
- carry_in  in  1  C input for ADD/SUB/ROR/ROL
- a  in  WIDTH  operand A (ADD, SUB, AND, ORA, EOR)
- b  in  WIDTH  operand B (all ops; sole operand of INC..ROL)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result and flags updated
- result  out  WIDTH  registered result
- c_out, v_out, n_out, z_out  out  1 each  registered flags

## Operation
- States: IDLE, RUN, FIN. IDLE/FIN + start → RUN; inputs op, d_flag, carry_in, a, b are captured on acceptance and ignored afterwards.
- RUN length: DIGITS cycles for ADD/SUB; 1 cycle for all other ops. RUN → FIN; FIN → IDLE, or → RUN if start=1.
- Binary ADD/SUB (SUB uses ~b): per digit, t = a_i + b'_i + c_i, 5 bits; c_{i+1} = t[4]; C = final carry.
- V (ADD/SUB, both modes) = (a[W-1] XNOR b'[W-1]) AND (x XOR a[W-1]), where x = bit 3 of the top-digit intermediate t (decimal ADD) or result[W-1] (otherwise).
- Decimal ADD: if t > 9 then t += 6; c_{i+1} = (t > 15); digit = t[3:0].
- Decimal SUB: binary carry chain unchanged; digit = t[3:0] when c_{i+1} = 1, else (t[3:0] − 6) mod 16.
- A binary carry chain runs alongside the decimal chain, so the pure binary result is available for flags.
- Logic ops: AND/ORA/EOR on a, b; PASS = b; C = 0; V = 0.
- INC/DEC: b ± 1 mod 2^W. C = carry of b + 1 (INC) or of b + all-ones (DEC); V = 0.
- Shift ops: LSR {res, C} = {0, b}; ASL {C, res} = {b, 0}; ROR {res, C} = {carry_in, b}; ROL {C, res} = {b, carry_in}; V = 0.
- Binary-mode flags: N = result[W-1]; Z = (result == 0).
- Illegal ops: result 0, C = 0, V = 0, N = 0, Z = 1.

## Timing
- Reset: busy = 0, done = 0, result = 0, c_out = v_out = n_out = z_out = 0; state IDLE.
- Reset mid-RUN aborts immediately; no done pulse; the next start behaves as if from IDLE.
- start accepted at edge k → busy = 1 from k+1 through the last RUN cycle.
- Arithmetic ops: done = 1 and outputs updated at edge k+DIGITS+1. Other ops: at edge k+2.
- busy = 0 while done = 1. start during FIN is accepted (back-to-back: one op per DIGITS+1 cycles).
- start while busy = 1 is ignored (not queued).
- Outputs hold their values between done pulses.

## Configuration
- BCD_SERIAL_ALU_NMOS_FLAGS_EN defined: NMOS decimal flags.
  - Decimal ADD: Z from the binary result; N = bit 3 of the top-digit intermediate t before its +6 adjust.
  - Decimal SUB: N and Z from the binary result.
- BCD_SERIAL_ALU_NMOS_FLAGS_EN undefined: decimal N = result[W-1] and Z = (result == 0), both from the final BCD result.
- C and V are identical in both builds.

## Test plan
- W=8, NMOS: ADD D=1, a=0x58, b=0x46, cin=1 → result 0x05, C=1, N=1, V=1, Z=0; done at k+3.
- W=8: ADD D=1, a=0x99, b=0x01, cin=0 → result 0x00, C=1. NMOS build: Z=0, N=1. Non-NMOS build: Z=1, N=0.
- W=8: SUB D=1, a=0x00, b=0x01, cin=1 → result 0x99, C=0, N=1, Z=0, V=0 (both builds).
- W=16: ADD D=0, a=0xFFFF, b=0x0001, cin=0 → result 0x0000, C=1, Z=1, V=0, N=0; busy high 4 cycles; done at k+5. Back-to-back start at done → second done 5 cycles later.
- W=8: ROR b=0x01, cin=1 → result 0x80, C=1, N=1, done at k+2. Start during busy ignored. Op 13 → result 0, Z=1.
- Reset pulse during RUN of a W=16 ADD → all outputs 0, no done. Following ADD 0x1234+0x1111 (D=1) → result 0x2345, C=0.
